inst_fetch: RTL

- Instruction-fetch stage and the master side of the i_fetch_inst interface; the instruction ROM is the slave.
- Owns the PC register and drives the ROM chip enable and address. The ROM returns data combinationally, in the same cycle.
- Registers the fetched word into the IF/ID pipeline register.
- Handles pipeline stall, branch redirect (MIPS delay-slot semantics), exception flush, and detection of misaligned fetch addresses.

---
 rtl/inst_fetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM
// (combinational read, same-cycle data) and registers the fetched word
// into the IF/ID pipeline register. Handles stall, delay-slot branch
// redirect, exception flush and misaligned-fetch detection.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] FLUSH_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction ROM (slave) side
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  // pipeline control
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  // IF/ID pipeline register
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_adel
);

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  logic [31:0] r_pc;
  logic        r_en;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_id_adel;

  logic        w_aligned;
  logic [31:0] w_pc_next;

  assign w_aligned = (r_pc[1:0] == 2'b00);

  // ROM is only accessed for an enabled, word-aligned PC
  assign rom_addr = r_pc;
  assign rom_en   = (r_en == CHIP_ENABLE && w_aligned) ? CHIP_ENABLE : CHIP_DISABLE;

  // Next-PC selection: flush > stall > branch > sequential (wraps at 2^32)
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (flush) begin
      w_pc_next = flush_pc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (branch_taken) begin
      w_pc_next = branch_target;
    end
  end

  // PC, fetch enable and IF/ID register update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_en       <= CHIP_DISABLE;
      r_id_inst  <= FLUSH_NOP;
      r_id_pc    <= 32'h0;
      r_id_valid <= 1'b0;
      r_id_adel  <= 1'b0;
    end else begin
      // fetching starts one edge after reset and stays on until next reset
      r_en <= CHIP_ENABLE;
      if (r_en == CHIP_ENABLE) begin
        r_pc <= w_pc_next;
      end

      if (flush || (!stall && r_en == CHIP_DISABLE)) begin
        // discarded fetch or startup bubble
        r_id_inst  <= FLUSH_NOP;
        r_id_pc    <= 32'h0;
        r_id_valid <= 1'b0;
        r_id_adel  <= 1'b0;
      end else if (!stall) begin
        if (!w_aligned) begin
          // misaligned fetch: no ROM access, report address error
          r_id_inst  <= FLUSH_NOP;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
          r_id_adel  <= 1'b1;
        end else begin
          r_id_inst  <= rom_data;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
          r_id_adel  <= 1'b0;
        end
      end
    end
  end

  assign id_inst  = r_id_inst;
  assign id_pc    = r_id_pc;
  assign id_valid = r_id_valid;
  assign id_adel  = r_id_adel;

endmodule
